clock_set_ctrl: RTL and testbench
=================================

# clock_set_ctrl

Mode and time-set controller for the 1 Hz digital clock counter datapath. It converts the raw mode, increment and decrement pushbuttons into single-cycle command pulses, and sequences the clock through RUN, SET_MIN and SET_SEC. It gates the seconds counter and returns to RUN after an inactivity timeout. It sits between the board pushbuttons and the seconds/minutes counter block, which consumes its outputs directly.

## Interface
- TIMEOUT_TICKS, default 10: idle cycles in a SET state before returning to RUN.
- HOLD_TICKS, default 2: cycles a button must be held after its press before auto-repeat starts.
- CNT_W, default 4: width of the timeout and hold counters. Must satisfy 2**CNT_W > max(TIMEOUT_TICKS, HOLD_TICKS).
- clk_1H  in  1  1 Hz system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- mode_pb  in  1  mode pushbutton, level, already synchronised.
- incr_pb  in  1  increment pushbutton, level.
- decr_pb  in  1  decrement pushbutton, level.
- sec_run_en  out  1  seconds counter may advance; 1 only in RUN.
- min_incr  out  1  one-cycle pulse: minutes +1.
- min_decr  out  1  one-cycle pulse: minutes −1.
- sec_clear  out  1  one-cycle pulse: seconds to 0.
- set_mode  out  2  current state code: RUN=00, SET_MIN=01, SET_SEC=10.
- blink  out  1  display-blink enable; toggles every cycle in SET states.

## Operation
- **Edge detection.** Each button has a registered previous-sample flop. A press is pb=1 with the previous sample 0.
- **State machine** (states RUN, SET_MIN, SET_SEC; 11 is unused and recovers to RUN next cycle). Each mode press advances the state:
  - RUN → SET_MIN
  - SET_MIN → SET_SEC
  - SET_SEC → RUN
- **RUN:** sec_run_en=1. incr/decr presses are ignored and no pulses are issued.
- **SET_MIN:** sec_run_en=0, so the clock is frozen.
  - An incr press gives min_incr.
  - A decr press gives min_decr.
  - Range limiting (0..59, no decrement below 0) is the counter's responsibility, not this block's.
- **SET_SEC:** sec_run_en=0. An incr or a decr press gives sec_clear.
- **Auto-repeat.**
  - Each incr/decr button has a hold counter, cleared on its press and incremented (saturating) while the level stays 1.
  - Once the counter reaches HOLD_TICKS, the command pulse is re-issued every cycle while the button is held.
  - Releasing the button clears the counter.
  - mode_pb has no auto-repeat.
- **Simultaneous events:**
  - incr and decr both active in the same cycle: both are dropped and no pulse is issued.
  - A mode press in the same cycle as an incr/decr event: the mode transition wins and the incr/decr event is dropped.
- **Command pulses** are mutually exclusive: at most one of min_incr, min_decr, sec_clear is high in any cycle.
- **blink:** cleared on every entry to RUN; inverts each cycle while in SET_MIN or SET_SEC.

## Timing
- **Reset values** (hold while reset=1 at an edge):
  - state RUN, so set_mode=00 and sec_run_en=1
  - min_incr=0, min_decr=0, sec_clear=0, blink=0
  - all counters 0; previous-sample flops 0
- **State-derived outputs:** sec_run_en and set_mode decode the state register (Moore). They change in the cycle after the edge that samples the mode press.
- **Command pulses** are registered, with latency 1. A press first sampled at edge N produces a pulse high from edge N to edge N+1.
- **Auto-repeat timing:** with the button held from edge N, repeat pulses are issued at edges N+HOLD_TICKS, N+HOLD_TICKS+1, and so on.
- **Reset mid-hold or mid-set:** returns to RUN immediately. A button still held when reset falls is not treated as a press, because its previous-sample flop loads the live level during reset.

## Configuration
- **SET_TIMEOUT_EN defined:**
  - An idle counter runs in SET_MIN and SET_SEC.
  - It clears on any button level high and on every state change.
  - When it reaches TIMEOUT_TICKS, the next state is RUN.
  - The timeout coinciding with a button press: the press wins and the counter clears.
- **SET_TIMEOUT_EN undefined:** the idle counter is absent, and the SET states are left only by mode presses or reset.

## Structure
- **Shared package clock_pkg** holds:
  - the state typedef and the encodings RUN, SET_MIN, SET_SEC
  - the set_mode width constant
  - the clock field limits (59), shared with the counter block
- **Sub-module pb_edge_repeat** (parameters HOLD_TICKS and CNT_W) holds the edge detector plus the hold counter. It has one output, a per-cycle event (press or repeat), and is instantiated for incr_pb and decr_pb.
- mode_pb uses an inline edge detector.

## Test plan
- **Reset:** reset=1 for 2 cycles, then release → set_mode=00, sec_run_en=1, all pulses 0, blink=0.
- **Mode cycling:** three mode presses, each 1 cycle wide → set_mode goes 01, 10, 00 in turn, one cycle after each press. sec_run_en=0 only during 01 and 10.
- **SET_MIN presses:** in SET_MIN, a 1-cycle incr press → exactly one min_incr pulse, one cycle later. A decr press → one min_decr pulse. incr and decr together → no pulse.
- **Auto-repeat:** in SET_MIN with HOLD_TICKS=2, hold incr for 6 cycles → min_incr high for 1 cycle, low for 1 cycle, then high for 4 consecutive cycles, then 0 after release.
- **Mode priority:** in SET_SEC, press mode and incr in the same cycle → set_mode=00, no sec_clear. Separately, an incr press in SET_SEC → one sec_clear pulse.
- **Timeout** (SET_TIMEOUT_EN, TIMEOUT_TICKS=10): enter SET_MIN, then no buttons → set_mode=00 after 10 idle cycles, blink=0. Without the macro → it remains 01 indefinitely.

Source files
------------

// File: rtl/clock_set_ctrl_pkg.sv
// Shared definitions for the digital clock: set-state encoding, set_mode width
// and clock field limits used by both this controller and the counter block.
package clock_pkg;

    localparam int unsigned MODE_W  = 2;
    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned MIN_MAX = 59;

    typedef enum logic [MODE_W-1:0] {
        RUN     = 2'b00,
        SET_MIN = 2'b01,
        SET_SEC = 2'b10,
        UNUSED  = 2'b11
    } set_state_e;

    function automatic logic is_set_state(input set_state_e s);
        return (s == SET_MIN) || (s == SET_SEC);
    endfunction

endpackage

// File: rtl/clock_set_ctrl_pb_edge_repeat.sv
// Pushbutton edge detector with hold-to-repeat: evt is high on the press cycle
// and on every cycle from HOLD_TICKS after the press while the level stays high.
module pb_edge_repeat #(
    parameter int unsigned HOLD_TICKS = 2,
    parameter int unsigned CNT_W      = 4
) (
    input  logic clk_1H,
    input  logic reset,
    input  logic pb,
    output logic evt
);

    logic             pb_prev;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_next;
    logic             press;
    logic             held;

    always_comb begin
        press     = pb && !pb_prev;
        held      = pb && pb_prev;
        hold_next = '0;
        if (held) begin
            hold_next = (hold_cnt == CNT_W'(HOLD_TICKS)) ? hold_cnt : hold_cnt + CNT_W'(1);
        end
        // Repeat is keyed on the post-edge count so it fires on the edge the count arrives
        evt = press || (held && (hold_next == CNT_W'(HOLD_TICKS)));
    end

    // pb_prev tracks the live level even in reset, so a button held across reset is no press
    always_ff @(posedge clk_1H) begin
        pb_prev <= pb;
        if (reset) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_next;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode/time-set controller for the 1 Hz clock: RUN -> SET_MIN -> SET_SEC on mode
// presses, registered command pulses, blink. SET_TIMEOUT_EN adds idle return to RUN.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned TIMEOUT_TICKS = 10,
    parameter int unsigned HOLD_TICKS    = 2,
    parameter int unsigned CNT_W         = 4
) (
    input  logic              clk_1H,
    input  logic              reset,
    input  logic              mode_pb,
    input  logic              incr_pb,
    input  logic              decr_pb,
    output logic              sec_run_en,
    output logic              min_incr,
    output logic              min_decr,
    output logic              sec_clear,
    output logic [MODE_W-1:0] set_mode,
    output logic              blink
);

    if ((2 ** CNT_W) <= TIMEOUT_TICKS || (2 ** CNT_W) <= HOLD_TICKS) begin : g_param_check
        $error("clock_set_ctrl: CNT_W too narrow for TIMEOUT_TICKS/HOLD_TICKS");
    end

    set_state_e state;
    set_state_e state_next;
    logic       mode_prev;
    logic       mode_press;
    logic       incr_evt;
    logic       decr_evt;
    logic       cmd_ok;
    logic       timeout;
    logic       min_incr_next;
    logic       min_decr_next;
    logic       sec_clear_next;
    logic       blink_next;

    pb_edge_repeat #(
        .HOLD_TICKS(HOLD_TICKS),
        .CNT_W     (CNT_W)
    ) u_incr (
        .clk_1H(clk_1H),
        .reset (reset),
        .pb    (incr_pb),
        .evt   (incr_evt)
    );

    pb_edge_repeat #(
        .HOLD_TICKS(HOLD_TICKS),
        .CNT_W     (CNT_W)
    ) u_decr (
        .clk_1H(clk_1H),
        .reset (reset),
        .pb    (decr_pb),
        .evt   (decr_evt)
    );

    assign mode_press = mode_pb && !mode_prev;

`ifdef SET_TIMEOUT_EN
    logic [CNT_W-1:0] idle_cnt;
    logic             any_btn;

    assign any_btn = mode_pb || incr_pb || decr_pb;
    // idle_cnt holds completed idle cycles; the TIMEOUT_TICKS-th idle cycle triggers the exit
    assign timeout = is_set_state(state) && !any_btn
                     && (idle_cnt == CNT_W'(TIMEOUT_TICKS - 1));

    always_ff @(posedge clk_1H) begin
        if (reset || !is_set_state(state) || any_btn || (state_next != state)) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + CNT_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (mode_press) state_next = SET_MIN;
            SET_MIN: if (mode_press) state_next = SET_SEC;
                     else if (timeout) state_next = RUN;
            SET_SEC: if (mode_press || timeout) state_next = RUN;
            default: state_next = RUN;
        endcase

        cmd_ok         = !mode_press && (incr_evt ^ decr_evt);
        min_incr_next  = cmd_ok && (state == SET_MIN) && incr_evt;
        min_decr_next  = cmd_ok && (state == SET_MIN) && decr_evt;
        sec_clear_next = cmd_ok && (state == SET_SEC);
        blink_next     = (is_set_state(state) && is_set_state(state_next)) ? !blink : 1'b0;
    end

    always_ff @(posedge clk_1H) begin
        mode_prev <= mode_pb;
        if (reset) begin
            state     <= RUN;
            min_incr  <= 1'b0;
            min_decr  <= 1'b0;
            sec_clear <= 1'b0;
            blink     <= 1'b0;
        end else begin
            state     <= state_next;
            min_incr  <= min_incr_next;
            min_decr  <= min_decr_next;
            sec_clear <= sec_clear_next;
            blink     <= blink_next;
        end
    end

    assign sec_run_en = (state == RUN);
    assign set_mode   = state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: cycle model plus directed literal checks.
// Honours SET_TIMEOUT_EN the same way as the design.
module tb_clock_set_ctrl;

    localparam int unsigned T_TICKS = 10;
    localparam int unsigned H_TICKS = 2;

    logic       clk_1H  = 1'b0;
    logic       reset   = 1'b1;
    logic       mode_pb = 1'b0;
    logic       incr_pb = 1'b0;
    logic       decr_pb = 1'b0;
    logic       sec_run_en, min_incr, min_decr, sec_clear, blink;
    logic [1:0] set_mode;

    int errors = 0;
    int checks = 0;

    always #5 clk_1H = ~clk_1H;

    clock_set_ctrl #(
        .TIMEOUT_TICKS(T_TICKS),
        .HOLD_TICKS   (H_TICKS),
        .CNT_W        (4)
    ) dut (
        .clk_1H    (clk_1H),
        .reset     (reset),
        .mode_pb   (mode_pb),
        .incr_pb   (incr_pb),
        .decr_pb   (decr_pb),
        .sec_run_en(sec_run_en),
        .min_incr  (min_incr),
        .min_decr  (min_decr),
        .sec_clear (sec_clear),
        .set_mode  (set_mode),
        .blink     (blink)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: state 0=RUN 1=SET_MIN 2=SET_SEC; runs count consecutive high samples
    int m_state   = 0;
    int m_inc_run = 0;
    int m_dec_run = 0;
    int m_idle    = 0;
    bit m_mode_last = 0;
    bit e_min_incr = 0, e_min_decr = 0, e_sec_clear = 0, e_blink = 0;
    bit chk_en = 0;

    always @(posedge clk_1H) begin
        bit mp, ie, de;
        int nxt;
        chk_en = 1;
        if (reset) begin
            m_state = 0; m_idle = 0;
            e_min_incr = 0; e_min_decr = 0; e_sec_clear = 0; e_blink = 0;
            m_mode_last = mode_pb;
            m_inc_run = incr_pb ? 1 : 0;
            m_dec_run = decr_pb ? 1 : 0;
        end else begin
            mp = mode_pb && !m_mode_last;
            m_mode_last = mode_pb;
            m_inc_run = incr_pb ? m_inc_run + 1 : 0;
            m_dec_run = decr_pb ? m_dec_run + 1 : 0;
            ie = (m_inc_run == 1) || (m_inc_run >= H_TICKS + 1);
            de = (m_dec_run == 1) || (m_dec_run >= H_TICKS + 1);
            nxt = mp ? (m_state + 1) % 3 : m_state;
`ifdef SET_TIMEOUT_EN
            if (m_state != 0 && !(mode_pb || incr_pb || decr_pb)) begin
                m_idle++;
                if (m_idle == T_TICKS) nxt = 0;
            end else begin
                m_idle = 0;
            end
            if (nxt != m_state) m_idle = 0;
`endif
            e_min_incr  = (m_state == 1) && ie && !de && !mp;
            e_min_decr  = (m_state == 1) && de && !ie && !mp;
            e_sec_clear = (m_state == 2) && (ie != de) && !mp;
            e_blink     = (nxt == 0) ? 1'b0 : ((m_state != 0) ? !e_blink : 1'b0);
            m_state = nxt;
        end
    end

    always @(negedge clk_1H) begin
        if (chk_en) begin
            check("set_mode",   set_mode,   m_state);
            check("sec_run_en", sec_run_en, m_state == 0);
            check("min_incr",   min_incr,   e_min_incr);
            check("min_decr",   min_decr,   e_min_decr);
            check("sec_clear",  sec_clear,  e_sec_clear);
            check("blink",      blink,      e_blink);
        end
    end

    task automatic step(input logic m, input logic i, input logic d);
        @(negedge clk_1H);
        #1;
        mode_pb = m; incr_pb = i; decr_pb = d;
        @(posedge clk_1H);
        #1;
    endtask

    initial begin
        logic [6:0] pat;
        int first;
        repeat (2) @(posedge clk_1H);
        @(negedge clk_1H);
        #1 reset = 1'b0;
        @(posedge clk_1H);
        #1;
        check("rst_set_mode", set_mode, 0);
        check("rst_run_en", sec_run_en, 1);
        check("rst_pulses", {min_incr, min_decr, sec_clear}, 0);
        check("rst_blink", blink, 0);

        step(0, 1, 0); check("run_ignores_incr", min_incr, 0);
        step(0, 0, 0);
        step(1, 0, 0); check("enter_set_min", set_mode, 1);
        check("set_min_frozen", sec_run_en, 0);
        step(0, 0, 0); check("blink_toggle", blink, 1);
        step(0, 1, 0); check("min_incr_pulse", min_incr, 1);
        step(0, 0, 0); check("min_incr_single", min_incr, 0);
        step(0, 0, 1); check("min_decr_pulse", min_decr, 1);
        step(0, 0, 0);
        step(0, 1, 1); check("both_dropped", {min_incr, min_decr}, 0);
        step(0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0);
            pat[i] = min_incr;
        end
        step(0, 0, 0);
        pat[6] = min_incr;
        check("auto_repeat_pattern", pat, 7'b0111101);

        step(1, 0, 0); check("enter_set_sec", set_mode, 2);
        step(0, 0, 0);
        step(0, 1, 0); check("sec_clear_pulse", sec_clear, 1);
        step(0, 0, 0); check("sec_clear_single", sec_clear, 0);
        step(1, 1, 0); check("mode_wins_state", set_mode, 0);
        check("mode_wins_no_clear", sec_clear, 0);
        step(0, 0, 0);

        step(1, 0, 0); check("timeout_entry", set_mode, 1);
        first = -1;
        for (int k = 1; k <= 14; k++) begin
            step(0, 0, 0);
            if (set_mode == 2'b00 && first < 0) first = k;
        end
`ifdef SET_TIMEOUT_EN
        check("timeout_cycles", first, T_TICKS);
        check("timeout_blink", blink, 0);
        step(1, 0, 0);
        step(0, 0, 0);
`else
        check("no_timeout", first, 32'hFFFF_FFFF);
        check("no_timeout_mode", set_mode, 1);
`endif

        step(0, 1, 0); check("pre_reset_pulse", min_incr, 1);
        reset = 1'b1;
        step(0, 1, 0); check("reset_mid_set", set_mode, 0);
        check("reset_mid_set_pulse", min_incr, 0);
        step(0, 1, 0);
        reset = 1'b0;
        step(0, 1, 0); check("held_through_reset", min_incr, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        step(1, 0, 0); check("post_reset_mode", set_mode, 1);
        step(0, 0, 0);
        step(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
